// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_t     : receiver FSM states
//   UART_DATA_BITS : data bits per frame (8N1)
//   counter_width  : width needed for a counter that runs 0..n-1
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // A counter that runs 0..n-1 needs clog2(n) bits; never return zero.
    function automatic int counter_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Consumer-side bundle of the UART receiver.
//   data_out        : received byte, stable while data_out_valid=1
//   data_out_valid  : holding register full
//   data_out_ready  : consumer accepts the byte this cycle
//   overrun         : sticky, a byte was dropped because the holding register was full
//   framing_error   : sticky, a stop bit was sampled as 0
//   clear_errors    : single-cycle pulse clearing both sticky flags
//   busy            : receiver FSM is not idle
// master = receiver side, slave = consumer (IO controller) side.
interface uart_receiver_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data_out;
    logic                      data_out_valid;
    logic                      data_out_ready;
    logic                      overrun;
    logic                      framing_error;
    logic                      clear_errors;
    logic                      busy;

    modport master (
        output data_out,
        output data_out_valid,
        input  data_out_ready,
        output overrun,
        output framing_error,
        input  clear_errors,
        output busy
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        output data_out_ready,
        input  overrun,
        input  framing_error,
        output clear_errors,
        input  busy
    );

endinterface

// File: rtl/uart_receiver_synchronizer.sv
// N-flop synchroniser for a single asynchronous input.
//   clk   : destination clock
//   rst   : asynchronous active-low reset; all flops reset to 1 (idle line level)
//   d     : asynchronous input
//   q     : synchronised output (last flop of the chain)
module synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        sync_reg[gi] <= 1'b1;
                    end else begin
                        sync_reg[gi] <= d;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        sync_reg[gi] <= 1'b1;
                    end else begin
                        sync_reg[gi] <= sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive front end.
//   clk        : core clock
//   rst        : asynchronous active-low reset
//   serial_in  : UART line, asynchronous to clk, idle high
//   rx_bus     : consumer bundle (byte holding register, handshake, sticky
//                error flags, clear pulse, busy)
// Bits are sampled mid-bit by a bit timer derived from CLOCK_FREQ/BAUD_RATE.
// Received bytes land in a single holding register with a ready/valid
// handshake; a byte arriving while the register is still full is dropped.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            serial_in,
    uart_receiver_if.master rx_bus
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int TIMER_W          = counter_width(SYMBOL_EDGE_TIME);
    localparam int INDEX_W          = counter_width(UART_DATA_BITS);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [TIMER_W-1:0] TIMER_MID  = TIMER_W'(SAMPLE_TIME - 1);
    localparam logic [INDEX_W-1:0] INDEX_LAST = INDEX_W'(UART_DATA_BITS - 1);

    logic                      rx_s;
    rx_state_t                 state_reg;
    logic [TIMER_W-1:0]        timer_reg;
    logic [INDEX_W-1:0]        index_reg;
    logic [UART_DATA_BITS-1:0] shift_reg;

    logic [UART_DATA_BITS-1:0] data_reg;
    logic                      valid_reg;
    logic                      overrun_reg;
    logic                      framing_reg;

    logic stop_sample;
    logic deliver;
    logic frame_err;
    logic drop;

    synchronizer #(
        .STAGES(2)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (serial_in),
        .q   (rx_s)
    );

    // ------------------------------------------------------------------
    // Receive FSM. The timer restarts at 0 on every state change; after the
    // START sample (half a bit in) every later sample lands one full bit
    // later, i.e. mid-bit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            index_reg <= '0;
            shift_reg <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    timer_reg <= '0;
                    if (!rx_s) begin
                        state_reg <= START;
                    end
                end

                START: begin
                    if (timer_reg == TIMER_MID) begin
                        timer_reg <= '0;
                        index_reg <= '0;
                        // A start bit that is high again by mid-bit was a glitch.
                        state_reg <= rx_s ? IDLE : DATA;
                    end else begin
                        timer_reg <= timer_reg + TIMER_W'(1);
                    end
                end

                DATA: begin
                    if (timer_reg == TIMER_LAST) begin
                        timer_reg <= '0;
                        // LSB arrives first, so shift in from the top.
                        shift_reg <= {rx_s, shift_reg[UART_DATA_BITS-1:1]};
                        index_reg <= index_reg + INDEX_W'(1);
                        if (index_reg == INDEX_LAST) begin
                            state_reg <= STOP;
                        end
                    end else begin
                        timer_reg <= timer_reg + TIMER_W'(1);
                    end
                end

                STOP: begin
                    if (timer_reg == TIMER_LAST) begin
                        timer_reg <= '0;
                        // Leaving at mid-stop-bit lets the next start edge resync.
                        state_reg <= rx_s ? IDLE : WAIT_HIGH;
                    end else begin
                        timer_reg <= timer_reg + TIMER_W'(1);
                    end
                end

                WAIT_HIGH: begin
                    // A held-low (break) line must not be taken as new frames.
                    timer_reg <= '0;
                    if (rx_s) begin
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    timer_reg <= '0;
                end
            endcase
        end
    end

    assign stop_sample = (state_reg == STOP) && (timer_reg == TIMER_LAST);
    assign deliver     = stop_sample && rx_s;
    assign frame_err   = stop_sample && !rx_s;
    // A byte is only dropped if the held byte is not leaving in this same cycle.
    assign drop        = deliver && valid_reg && !rx_bus.data_out_ready;

    // ------------------------------------------------------------------
    // Holding register and sticky flags. New errors take priority over
    // clear_errors arriving in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
            framing_reg <= 1'b0;
        end else begin
            if (deliver && (!valid_reg || rx_bus.data_out_ready)) begin
                data_reg  <= shift_reg;
                valid_reg <= 1'b1;
            end else if (valid_reg && rx_bus.data_out_ready) begin
                valid_reg <= 1'b0;
            end

            if (drop) begin
                overrun_reg <= 1'b1;
            end else if (rx_bus.clear_errors) begin
                overrun_reg <= 1'b0;
            end

            if (frame_err) begin
                framing_reg <= 1'b1;
            end else if (rx_bus.clear_errors) begin
                framing_reg <= 1'b0;
            end
        end
    end

    assign rx_bus.data_out       = data_reg;
    assign rx_bus.data_out_valid = valid_reg;
    assign rx_bus.overrun        = overrun_reg;
    assign rx_bus.framing_error  = framing_reg;
    assign rx_bus.busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Randomised and directed bench for uart_receiver at 10 clocks per bit.
// The reference model works at frame level: each completed frame either
// lands in the holding register, is consumed, is dropped (overrun) or is
// discarded (framing error); accepted bytes are compared in order.
module tb_uart_receiver;

    localparam int CLOCK_FREQ = 1000;
    localparam int BAUD_RATE  = 100;
    localparam int BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;
    // Start-edge to valid: 2 sync flops + 1 cycle to leave IDLE + half a bit
    // to the start sample + 9 full bits to the stop sample.
    localparam int EXP_LATENCY = 2 + 1 + (BIT_CYCLES / 2) + 9 * BIT_CYCLES;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic serial_in = 1'b1;
    logic ready_pulse = 1'b0;
    logic auto_ready = 1'b0;

    uart_receiver_if bus ();

    uart_receiver #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .rx_bus    (bus)
    );

    always #5 clk = ~clk;

    // Consumer: either a manual one-cycle pulse, or accept whenever valid.
    assign bus.data_out_ready = auto_ready ? bus.data_out_valid : ready_pulse;

    int n_compared = 0;
    int n_mismatched = 0;

    // Reference model state
    logic [7:0] exp_data = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_overrun = 1'b0;
    logic       exp_framing = 1'b0;
    logic [7:0] exp_accepted[$];
    logic [7:0] got_accepted[$];

    int cycle = 0;
    int start_cycle = 0;
    int rise_cycle = -1;
    logic valid_prev = 1'b0;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (rst && bus.data_out_valid && bus.data_out_ready) begin
            got_accepted.push_back(bus.data_out);
        end
    end

    always @(negedge clk) begin
        if (bus.data_out_valid && !valid_prev) begin
            rise_cycle = cycle;
        end
        valid_prev = bus.data_out_valid;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_line(input logic v);
        serial_in = v;
        repeat (BIT_CYCLES) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic consuming);
        start_cycle = cycle;
        hold_line(1'b0);
        for (int i = 0; i < 8; i++) begin
            hold_line(b[i]);
        end
        hold_line(stop_bit);
        if (consuming) begin
            if (exp_valid) begin
                exp_accepted.push_back(exp_data);
            end
            exp_valid = 1'b0;
            if (stop_bit) begin
                exp_accepted.push_back(b);
            end
        end else if (stop_bit) begin
            if (exp_valid) begin
                exp_overrun = 1'b1;
            end else begin
                exp_valid = 1'b1;
                exp_data  = b;
            end
        end
        if (!stop_bit) begin
            exp_framing = 1'b1;
        end
        $display("frame 0x%02h stop=%0d consuming=%0d", b, stop_bit, consuming);
    endtask

    task automatic pulse_ready();
        ready_pulse = 1'b1;
        @(negedge clk);
        ready_pulse = 1'b0;
        if (exp_valid) begin
            exp_accepted.push_back(exp_data);
        end
        exp_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear_errors = 1'b1;
        @(negedge clk);
        bus.clear_errors = 1'b0;
        exp_overrun = 1'b0;
        exp_framing = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic exp_busy);
        check_value({tag, ".valid"}, 32'(bus.data_out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check_value({tag, ".data"}, 32'(bus.data_out), 32'(exp_data));
        end
        check_value({tag, ".overrun"}, 32'(bus.overrun), 32'(exp_overrun));
        check_value({tag, ".framing"}, 32'(bus.framing_error), 32'(exp_framing));
        check_value({tag, ".busy"}, 32'(bus.busy), 32'(exp_busy));
    endtask

    logic [7:0] rnd_byte;
    logic       rnd_stop;
    logic       rnd_cons;

    initial begin
        bus.clear_errors = 1'b0;

        // Reset state
        idle(3);
        check_value("reset.data", 32'(bus.data_out), 32'h0);
        check_outputs("reset", 1'b0);
        rst = 1'b1;
        idle(5);

        // Single frame, ready held low; check latency
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(5);
        check_outputs("a5", 1'b0);
        check_value("a5.latency", 32'(rise_cycle - start_cycle), 32'(EXP_LATENCY));
        pulse_ready();
        idle(3);
        check_outputs("a5_drained", 1'b0);

        // Back-to-back frames, consumer accepting each byte as it appears
        auto_ready = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b1);
        send_frame(8'hC3, 1'b1, 1'b1);
        idle(5);
        auto_ready = 1'b0;
        check_outputs("b2b", 1'b0);

        // Overrun: two frames with no consumer, then clear
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
        idle(5);
        check_outputs("ovr", 1'b0);
        pulse_clear();
        check_outputs("ovr_clr", 1'b0);
        pulse_ready();

        // Framing error followed by a held-low break line
        send_frame(8'h55, 1'b0, 1'b0);
        serial_in = 1'b0;
        idle(50);
        check_outputs("break", 1'b1);
        serial_in = 1'b1;
        idle(15);
        check_outputs("break_end", 1'b0);
        send_frame(8'h12, 1'b1, 1'b0);
        idle(5);
        check_outputs("after_break", 1'b0);
        pulse_clear();

        // Short glitch on the idle line
        serial_in = 1'b0;
        idle(3);
        serial_in = 1'b1;
        idle(2);
        check_value("glitch.busy_mid", 32'(bus.busy), 32'h1);
        idle(15);
        check_outputs("glitch", 1'b0);

        // Reset in the middle of the data bits
        serial_in = 1'b0;
        idle(BIT_CYCLES);
        hold_line(1'b1);
        hold_line(1'b0);
        hold_line(1'b1);
        rst = 1'b0;
        #1;
        exp_valid = 1'b0;
        exp_overrun = 1'b0;
        exp_framing = 1'b0;
        check_value("rst_mid.data", 32'(bus.data_out), 32'h0);
        check_outputs("rst_mid", 1'b0);
        serial_in = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(12);
        send_frame(8'h7E, 1'b1, 1'b0);
        idle(5);
        check_outputs("after_rst", 1'b0);

        // Randomised frames
        for (int it = 0; it < 24; it++) begin
            rnd_byte = 8'($urandom);
            rnd_stop = ($urandom_range(0, 5) != 0);
            rnd_cons = ($urandom_range(0, 3) == 0);
            auto_ready = rnd_cons;
            send_frame(rnd_byte, rnd_stop, rnd_cons);
            if (!rnd_stop) begin
                serial_in = 1'b0;
                idle($urandom_range(0, 30));
                serial_in = 1'b1;
            end
            idle(5);
            auto_ready = 1'b0;
            idle(8);
            check_outputs("rnd", 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                pulse_ready();
            end
            if ($urandom_range(0, 3) == 0) begin
                pulse_clear();
            end
        end

        // Drain and compare every accepted byte in order
        pulse_ready();
        idle(3);
        check_value("accepted.count", 32'(got_accepted.size()), 32'(exp_accepted.size()));
        for (int i = 0; i < exp_accepted.size() && i < got_accepted.size(); i++) begin
            check_value($sformatf("accepted[%0d]", i), 32'(got_accepted[i]), 32'(exp_accepted[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
